// File: rtl/data_cache_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : data_cache_responder                                          |
// | Purpose  : Memory-stage data port responder. Direct-mapped, one word per |
// |            line, write-through, no-write-allocate cache in front of a    |
// |            valid/ready backing memory with a single-beat read return.    |
// | Options  : DCACHE_STATS_EN adds saturating hit_count / miss_count ports. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module data_cache_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_re,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [2:0]            cpu_size,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int LINES = 1 << INDEX_BITS;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_REQ  = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;
  localparam logic [1:0] S_WR_REQ  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_BITS-1:0]   tag_mem_q  [LINES];
  logic [DATA_WIDTH-1:0] data_mem_q [LINES];

  logic                  mem_req_valid_q, mem_req_valid_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_wstrb_q, mem_wstrb_d;

  // Completed-store marker: a store still presented after its write-through
  // finished must not be issued again.
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] done_addr_q, done_addr_d;
  logic [4:0]            done_cmd_q, done_cmd_d;

  logic [INDEX_BITS-1:0] index, fill_index, data_idx;
  logic [TAG_BITS-1:0]   tag, fill_tag;
  logic [1:0]            off;
  logic [4:0]            cmd;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [DATA_WIDTH-1:0] line, st_lanes, st_line, ld_data, rdata_c, data_wdata;
  logic [3:0]            st_strb;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic                  hit, done_match, fill, data_we, stall_c;

  assign index      = cpu_addr[INDEX_BITS+1:2];
  assign tag        = cpu_addr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign off        = cpu_addr[1:0];
  assign word_addr  = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
  assign cmd        = {cpu_we, cpu_re, cpu_size};
  assign line       = data_mem_q[index];
  assign hit        = valid_q[index] && (tag_mem_q[index] == tag);
  assign done_match = done_q && (cpu_addr == done_addr_q) && (cmd == done_cmd_q);
  // Fills use the latched request address so the line lands where it was fetched.
  assign fill_index = mem_addr_q[INDEX_BITS+1:2];
  assign fill_tag   = mem_addr_q[ADDR_WIDTH-1:INDEX_BITS+2];
  assign fill       = (state_q == S_RD_WAIT) && mem_rvalid;

  // Store lane placement, line merge and load extraction.
  always_comb begin
    case (cpu_size[1:0])
      2'b00: begin
        st_strb  = 4'b0001 << off;
        st_lanes = {24'b0, cpu_wdata[7:0]} << {off, 3'b000};
      end
      2'b01: begin
        st_strb  = 4'b0011 << {off[1], 1'b0};
        st_lanes = {16'b0, cpu_wdata[15:0]} << {off[1], 4'b0000};
      end
      default: begin
        st_strb  = 4'b1111;
        st_lanes = cpu_wdata;
      end
    endcase
    for (int b = 0; b < 4; b++) begin
      st_line[8*b +: 8] = st_strb[b] ? st_lanes[8*b +: 8] : line[8*b +: 8];
    end
    ld_byte = line[{off, 3'b000} +: 8];
    ld_half = line[{off[1], 4'b0000} +: 16];
    case (cpu_size)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = line;
    endcase
  end

  // Controller: next state, request registers, array write port, stall.
  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_wstrb_d     = mem_wstrb_q;
    done_d          = done_q;
    done_addr_d     = done_addr_q;
    done_cmd_d      = done_cmd_q;
    stall_c         = 1'b0;
    rdata_c         = '0;
    data_we         = 1'b0;
    data_idx        = index;
    data_wdata      = st_line;
    case (state_q)
      S_IDLE: begin
        done_d = done_match;
        if (cpu_we) begin
          if (!done_match) begin
            stall_c         = 1'b1;
            data_we         = hit;
            state_d         = S_WR_REQ;
            mem_req_valid_d = 1'b1;
            mem_we_d        = 1'b1;
            mem_addr_d      = word_addr;
            mem_wdata_d     = st_lanes;
            mem_wstrb_d     = st_strb;
          end
        end else if (cpu_re) begin
          if (hit) begin
            rdata_c = ld_data;
          end else begin
            stall_c         = 1'b1;
            state_d         = S_RD_REQ;
            mem_req_valid_d = 1'b1;
            mem_we_d        = 1'b0;
            mem_addr_d      = word_addr;
            mem_wdata_d     = '0;
            mem_wstrb_d     = 4'b0000;
          end
        end
      end
      S_RD_REQ: begin
        stall_c = 1'b1;
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        stall_c = 1'b1;
        if (mem_rvalid) begin
          data_we             = 1'b1;
          data_idx            = fill_index;
          data_wdata          = mem_rdata;
          valid_d[fill_index] = 1'b1;
          state_d             = S_IDLE;
        end
      end
      S_WR_REQ: begin
        stall_c = 1'b1;
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          mem_we_d        = 1'b0;
          state_d         = S_IDLE;
          done_d          = 1'b1;
          done_addr_d     = cpu_addr;
          done_cmd_d      = cmd;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and request registers; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      valid_q         <= '0;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_wstrb_q     <= 4'b0000;
      done_q          <= 1'b0;
      done_addr_q     <= '0;
      done_cmd_q      <= 5'b0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wstrb_q     <= mem_wstrb_d;
      done_q          <= done_d;
      done_addr_q     <= done_addr_d;
      done_cmd_q      <= done_cmd_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (!rst && data_we) data_mem_q[data_idx] <= data_wdata;
    if (!rst && fill)    tag_mem_q[fill_index] <= fill_tag;
  end

  assign cpu_stall     = rst ? 1'b0 : stall_c;
  assign cpu_rdata     = rst ? '0 : rdata_c;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wstrb     = mem_wstrb_q;

`ifdef DCACHE_STATS_EN
  logic        refill_q, refill_d;
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  // Saturating counters; the hit that closes a refill is not a true hit.
  always_comb begin
    refill_d     = fill;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if ((state_q == S_IDLE) && cpu_re && !cpu_we && hit && !refill_q &&
        (hit_count_q != 32'hFFFF_FFFF))
      hit_count_d = hit_count_q + 32'd1;
    if ((state_q == S_IDLE) && (state_d == S_RD_REQ) &&
        (miss_count_q != 32'hFFFF_FFFF))
      miss_count_d = miss_count_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      refill_q     <= 1'b0;
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      refill_q     <= refill_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
`default_nettype wire
